// File: rtl/rmw_lsu.sv
// Load/store unit for a single-ported, word-wide data memory. Sub-word stores
// are done as a read-modify-write over three cycles; loads and SW take one.
`timescale 1ns/1ps
module rmw_lsu #(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        fault,
    output logic [31:0] mem_adr,
    input  logic [31:0] mem_rd,
    output logic        mem_we,
    output logic [31:0] mem_wd
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] merge_q;
    logic [31:0] offset;
    logic        req_fault;
    logic        accept;
    logic        word_store;
    logic        sub_store;
    logic        load;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] ext_data;
    logic [31:0] merged;

    assign mem_adr = {addr[31:2], 2'b00};
    assign offset  = addr - MEM_BASE;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        req_fault = 1'b0;
        case (funct3)
            3'b000, 3'b100: req_fault = 1'b0;
            3'b001, 3'b101: req_fault = addr[0];
            3'b010:         req_fault = (addr[1:0] != 2'b00);
            default:        req_fault = 1'b1;
        endcase
        if (req_we && funct3[2]) req_fault = 1'b1;
        if (offset >= MEM_BYTES) req_fault = 1'b1;
    end

    assign accept     = req_valid && !req_fault && (state == IDLE);
    assign word_store = accept && req_we && funct3[1];
    assign sub_store  = accept && req_we && !funct3[1];
    assign load       = accept && !req_we;

    assign lane_byte = 8'(mem_rd >> {addr[1:0], 3'b000});
    assign lane_half = addr[1] ? mem_rd[31:16] : mem_rd[15:0];

    always_comb begin
        ext_data = 32'h0;
        case (funct3)
            3'b000:  ext_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  ext_data = {24'h0, lane_byte};
            3'b001:  ext_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  ext_data = {16'h0, lane_half};
            3'b010:  ext_data = mem_rd;
            default: ext_data = 32'h0;
        endcase
    end

    // Request is held stable through the RMW, so the lane comes straight from addr.
    always_comb begin
        merged = merge_q;
        if (funct3[0]) merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        else           merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments only; the merge register
    // is an ordinary flop and is reset along with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            merge_q <= 32'h0;
        end else begin
            case (state)
                IDLE: if (sub_store) state <= RMW_RD;
                RMW_RD: begin
                    merge_q <= mem_rd;
                    state   <= RMW_WR;
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by rst_n so an asserted reset kills a pending write at once.
    assign stall   = rst_n && (sub_store || (state == RMW_RD));
    assign mem_we  = rst_n && (word_store || (state == RMW_WR));
    assign mem_wd  = (state == RMW_WR) ? merged : wdata;
    assign fault   = rst_n && (state == IDLE) && req_valid && req_fault;
    assign ld_data = (rst_n && load) ? ext_data : 32'h0;

endmodule

// File: tb/tb_rmw_lsu.sv
// Randomised self-checking bench for rmw_lsu against a word-array reference model.
`timescale 1ns/1ps
module tb_rmw_lsu;

    localparam int unsigned WORDS = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [31:0] ld_data;
    logic        fault;
    logic [31:0] mem_adr;
    logic [31:0] mem_rd;
    logic        mem_we;
    logic [31:0] mem_wd;

    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];
    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;
    int exp_we   = 0;

    rmw_lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .ld_data   (ld_data),
        .fault     (fault),
        .mem_adr   (mem_adr),
        .mem_rd    (mem_rd),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_adr[15:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_adr[15:2]] <= mem_wd;
            we_count <= we_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_fault(bit we, logic [2:0] f, logic [31:0] a);
        int unsigned sz;
        case (f)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            3'd4: begin if (we) return 1'b1; sz = 1; end
            3'd5: begin if (we) return 1'b1; sz = 2; end
            default: return 1'b1;
        endcase
        if ((a % sz) != 0) return 1'b1;
        if (a >= 32'h0001_0000) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(logic [31:0] cur, logic [2:0] f, logic [31:0] a);
        logic [31:0] raw;
        logic [31:0] v;
        raw = cur >> (8 * (a % 4));
        case (f)
            3'd0: begin v = raw & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'd4: v = raw & 32'hFF;
            3'd1: begin v = raw & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'd5: v = raw & 32'hFFFF;
            default: v = cur;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_merge(logic [31:0] cur, logic [2:0] f, logic [31:0] a,
                                              logic [31:0] wd);
        logic [31:0] mask;
        logic [31:0] val;
        int unsigned sh;
        sh = 8 * (a % 4);
        if (f == 3'd1) begin mask = 32'hFFFF << sh; val = (wd & 32'hFFFF) << sh; end
        else           begin mask = 32'hFF << sh;   val = (wd & 32'hFF) << sh;   end
        return (cur & ~mask) | val;
    endfunction

    // Called just after a rising edge; leaves just after the edge that completes the request.
    task automatic run_req(input bit we, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] wd);
        logic [31:0] cur;
        logic [31:0] nv;
        req_valid = 1'b1; req_we = we; funct3 = f; addr = a; wdata = wd;
        cur = ref_mem[a[15:2]];
        @(negedge clk);
        if (exp_fault(we, f, a)) begin
            check("fault", {31'h0, fault}, 32'h1);
            check("fault_stall", {31'h0, stall}, 32'h0);
            check("fault_we", {31'h0, mem_we}, 32'h0);
        end else if (!we) begin
            check("ld_fault", {31'h0, fault}, 32'h0);
            check("ld_stall", {31'h0, stall}, 32'h0);
            check("ld_data", ld_data, exp_load(cur, f, a));
        end else if (f == 3'd2) begin
            check("sw_stall", {31'h0, stall}, 32'h0);
            check("sw_we", {31'h0, mem_we}, 32'h1);
            check("sw_wd", mem_wd, wd);
            ref_mem[a[15:2]] = wd;
            exp_we++;
        end else begin
            nv = exp_merge(cur, f, a, wd);
            check("rmw_c1_stall", {31'h0, stall}, 32'h1);
            check("rmw_c1_we", {31'h0, mem_we}, 32'h0);
            @(negedge clk);
            check("rmw_c2_stall", {31'h0, stall}, 32'h1);
            check("rmw_c2_we", {31'h0, mem_we}, 32'h0);
            @(negedge clk);
            check("rmw_c3_stall", {31'h0, stall}, 32'h0);
            check("rmw_c3_we", {31'h0, mem_we}, 32'h1);
            check("rmw_c3_wd", mem_wd, nv);
            ref_mem[a[15:2]] = nv;
            exp_we++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_ld", ld_data, 32'h0);
        check("idle_we", {31'h0, mem_we}, 32'h0);
        check("idle_stall", {31'h0, stall}, 32'h0);
        check("idle_fault", {31'h0, fault}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = (i < 64) ? $urandom : 32'h0;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        mem[5] = 32'h0000_0088; ref_mem[5] = 32'h0000_0088;
        mem[8] = 32'h0;         ref_mem[8] = 32'h0;

        // Reset state.
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd0; addr = 32'h11;
        #12;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_we", {31'h0, mem_we}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_ld", ld_data, 32'h0);
        req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed loads on the reference word.
        run_req(1'b0, 3'd0, 32'h12, 32'h0);
        run_req(1'b0, 3'd1, 32'h12, 32'h0);
        run_req(1'b0, 3'd4, 32'h14, 32'h0);
        run_req(1'b0, 3'd0, 32'h14, 32'h0);
        run_req(1'b0, 3'd2, 32'h10, 32'h0);

        // Directed stores, back to back.
        run_req(1'b1, 3'd0, 32'h11, 32'hAABB_CCDD);
        run_req(1'b1, 3'd1, 32'h22, 32'h0000_BEEF);
        run_req(1'b1, 3'd2, 32'h24, 32'h5555_AAAA);
        idle_cycle();
        check("sb_word", mem[4], 32'h1122_DD44);
        check("sh_word", mem[8], 32'hBEEF_0000);

        // Faulting requests.
        run_req(1'b0, 3'd2, 32'h13, 32'h0);
        run_req(1'b1, 3'd1, 32'h01, 32'h1234);
        run_req(1'b0, 3'd3, 32'h10, 32'h0);
        run_req(1'b0, 3'd2, 32'h0001_0000, 32'h0);
        idle_cycle();

        // Reset during RMW_RD aborts the store.
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd0; addr = 32'h10; wdata = 32'hFF;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_rd_we", {31'h0, mem_we}, 32'h0);
        check("abort_rd_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        run_req(1'b0, 3'd2, 32'h10, 32'h0);

        // Reset during RMW_WR, before the write edge.
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd1; addr = 32'h12; wdata = 32'h7777;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_wr_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0; rst_n = 1'b1;
        run_req(1'b0, 3'd2, 32'h10, 32'h0);
        check("abort_writes", we_count, exp_we);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) a = 32'h0001_0000 + $urandom_range(0, 255);
            else                            a = $urandom_range(0, 127);
            if ($urandom_range(0, 9) == 0) idle_cycle();
            else run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
        idle_cycle();

        for (int w = 0; w < 32; w++) run_req(1'b0, 3'd2, 32'(w * 4), 32'h0);
        check("write_count", we_count, exp_we);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
